// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port scoreboarded register file:
// width defaults, reset-profile encodings and the reset-value lookup.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;

  localparam int PROFILE_ZERO = 0;
  localparam int PROFILE_BOOT = 1;

  // Boot profile seeds the small registers that early pipeline firmware expects.
  function automatic logic [31:0] init_val(input int profile, input int idx);
    if (profile == PROFILE_ZERO) return 32'h0;
    if (profile != PROFILE_BOOT) return 32'h0;
    case (idx)
      1:       return 32'h32;
      2:       return 32'h28;
      3:       return 32'h24;
      4:       return 32'h20;
      5:       return 32'h16;
      6:       return 32'h12;
      7:       return 32'h8;
      8:       return 32'h4;
      30:      return 32'h4;
      31:      return 32'h7;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Bus between the pipeline (ID issue/read, WB write) and the register file.
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);

  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]    rpend;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              flush;
  logic              any_pend;

  modport master (
    output we, waddr, wdata, raddr, issue_valid, issue_rd, flush,
    input  rdata, rpend, any_pend
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue_valid, issue_rd, flush,
    output rdata, rpend, any_pend
  );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write bits per register: flush > issue > write-clear > hold,
// plus per-port pending flags masked by a same-cycle write.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              flush,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD-1:0]    rpend,
  output logic              any_pend
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;

  // Issue beats a same-cycle clear: the newer producer is still in flight.
  always_comb begin
    pend_next = '0;
    for (int r = 1; r < NREGS; r++) begin
      if (flush)
        pend_next[r] = 1'b0;
      else if (issue_valid && issue_rd == AW'(r))
        pend_next[r] = 1'b1;
      else if (we && waddr == AW'(r))
        pend_next[r] = 1'b0;
      else
        pend_next[r] = pend[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pend <= '0;
    else
      pend <= pend_next;
  end

  // A register written this cycle is served by the bypass, so it is not reported pending.
  always_comb begin
    rpend = '0;
    for (int i = 0; i < NRD; i++)
      rpend[i] = pend[raddr[i*AW +: AW]] & ~(we && waddr == raddr[i*AW +: AW]);
  end

  assign any_pend = |pend;

endmodule

// File: rtl/regfile_mp_sb.sv
// Register file with one write port, NRD bypassed read ports, hardwired x0
// and an integrated RAW scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NREGS        = 32,
  parameter int AW           = AW_DEF,
  parameter int NRD          = 2,
  parameter int INIT_PROFILE = PROFILE_BOOT
) (
  input logic            clk,
  input logic            reset,
  regfile_mp_sb_if.slave bus
);

  logic [XLEN-1:0] mem    [NREGS];
  logic [XLEN-1:0] rd_val [NRD];

  // mem[0] is seeded to zero and never written, so x0 stays hardwired.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= XLEN'(init_val(INIT_PROFILE, r));
    end else if (bus.we && bus.waddr != '0) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_val[i] = (bus.raddr[i*AW +: AW] == '0)                  ? '0 :
                       (bus.we && bus.waddr == bus.raddr[i*AW +: AW]) ? bus.wdata :
                                                                        mem[bus.raddr[i*AW +: AW]];
  end

  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NRD; i++)
      bus.rdata[i*XLEN +: XLEN] = rd_val[i];
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW),
    .NRD   (NRD)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .we          (bus.we),
    .waddr       (bus.waddr),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .flush       (bus.flush),
    .raddr       (bus.raddr),
    .rpend       (bus.rpend),
    .any_pend    (bus.any_pend)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed, table-driven bench for regfile_mp_sb with boot profile and two read ports.
module tb_regfile_mp_sb;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  regfile_mp_sb_if #(.XLEN(32), .AW(5), .NRD(2)) bus ();

  regfile_mp_sb #(
    .XLEN(32), .NREGS(32), .AW(5), .NRD(2), .INIT_PROFILE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iv;
    logic [4:0]  ird;
    logic        flush;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rpend;
    logic        e_any;
  } vec_t;

  vec_t vecs [21];

  task automatic applyStimulus(input vec_t v);
    bus.we          = v.we;
    bus.waddr       = v.waddr;
    bus.wdata       = v.wdata;
    bus.raddr       = {v.ra1, v.ra0};
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.ird;
    bus.flush       = v.flush;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [1:0] erp, input logic eany);
    checkOutput({tag, "_rd0"}, bus.rdata[31:0], e0);
    checkOutput({tag, "_rd1"}, bus.rdata[63:32], e1);
    checkOutput({tag, "_rpend"}, {30'd0, bus.rpend}, {30'd0, erp});
    checkOutput({tag, "_any"}, {31'd0, bus.any_pend}, {31'd0, eany});
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic iv, input logic [4:0] ird, input logic fl,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] erp, input logic eany);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.ra0 = ra0; v.ra1 = ra1;
    v.iv = iv; v.ird = ird; v.flush = fl;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_rpend = erp; v.e_any = eany;
    return v;
  endfunction

  initial begin
    tests = 0;
    fails = 0;

    // Expected values are the combinational view during each cycle, before its edge.
    vecs[0]  = mk(0, 0,  0,            1, 31, 0, 0, 0, 32'h32,       32'h7,        2'b00, 0);
    vecs[1]  = mk(1, 5,  32'hDEADBEEF, 5, 6,  0, 0, 0, 32'hDEADBEEF, 32'h12,       2'b00, 0);
    vecs[2]  = mk(0, 0,  0,            5, 0,  0, 0, 0, 32'hDEADBEEF, 32'h0,        2'b00, 0);
    vecs[3]  = mk(1, 0,  32'hFFFFFFFF, 0, 8,  1, 0, 0, 32'h0,        32'h4,        2'b00, 0);
    vecs[4]  = mk(0, 0,  0,            0, 8,  0, 0, 0, 32'h0,        32'h4,        2'b00, 0);
    vecs[5]  = mk(0, 0,  0,            7, 7,  1, 7, 0, 32'h8,        32'h8,        2'b00, 0);
    vecs[6]  = mk(0, 0,  0,            1, 7,  0, 0, 0, 32'h32,       32'h8,        2'b10, 1);
    vecs[7]  = mk(1, 7,  32'h55,       7, 7,  1, 7, 0, 32'h55,       32'h55,       2'b00, 1);
    vecs[8]  = mk(0, 0,  0,            2, 7,  0, 0, 0, 32'h28,       32'h55,       2'b10, 1);
    vecs[9]  = mk(1, 7,  32'h66,       7, 3,  0, 0, 0, 32'h66,       32'h24,       2'b00, 1);
    vecs[10] = mk(0, 0,  0,            7, 3,  0, 0, 0, 32'h66,       32'h24,       2'b00, 0);
    vecs[11] = mk(0, 0,  0,            3, 9,  1, 3, 0, 32'h24,       32'h0,        2'b00, 0);
    vecs[12] = mk(0, 0,  0,            3, 9,  1, 9, 0, 32'h24,       32'h0,        2'b01, 1);
    vecs[13] = mk(0, 0,  0,            3, 9,  1, 4, 1, 32'h24,       32'h0,        2'b11, 1);
    vecs[14] = mk(0, 0,  0,            4, 9,  0, 0, 0, 32'h20,       32'h0,        2'b00, 0);
    vecs[15] = mk(0, 0,  0,            3, 4,  0, 0, 0, 32'h24,       32'h20,       2'b00, 0);
    vecs[16] = mk(1, 10, 32'hA5A5,     10, 10, 0, 0, 0, 32'hA5A5,    32'hA5A5,     2'b00, 0);
    vecs[17] = mk(0, 0,  0,            10, 30, 0, 0, 0, 32'hA5A5,    32'h4,        2'b00, 0);
    vecs[18] = mk(0, 0,  0,            2, 2,  1, 2, 0, 32'h28,       32'h28,       2'b00, 0);
    vecs[19] = mk(1, 2,  32'h1234,     2, 1,  0, 0, 0, 32'h1234,     32'h32,       2'b00, 1);
    vecs[20] = mk(0, 0,  0,            2, 5,  1, 2, 0, 32'h1234,     32'hDEADBEEF, 2'b00, 0);

    // Power-on reset with a write and an issue that must both be ignored.
    reset = 1'b1;
    applyStimulus(mk(1, 3, 32'hBAD, 1, 31, 1, 3, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(mk(0, 0, 0, 3, 31, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkAll("reset", 32'h24, 32'h7, 2'b00, 1'b0);

    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkAll($sformatf("v%0d", i), vecs[i].e_rd0, vecs[i].e_rd1, vecs[i].e_rpend, vecs[i].e_any);
    end

    // r2 is pending from the last vector; a reset must drop it and the concurrent write.
    @(posedge clk);
    #1;
    applyStimulus(mk(0, 0, 0, 2, 5, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkAll("pre_reset", 32'h1234, 32'hDEADBEEF, 2'b01, 1'b1);

    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(mk(1, 2, 32'h9999, 2, 5, 1, 5, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(mk(0, 0, 0, 2, 5, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkAll("post_reset", 32'h28, 32'h16, 2'b00, 1'b0);

    @(posedge clk);
    #1;
    applyStimulus(mk(0, 0, 0, 7, 10, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkAll("post_reset_b", 32'h8, 32'h0, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
